// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the iterative MIPS divider.
package div_pkg;

  localparam int DATA_W     = 32;
  localparam int DIV_CYCLES = DATA_W;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX-stage divider bus: decoded request and operands in, stall and HI/LO results out.
interface div_unit_if;
  import div_pkg::*;

  logic [5:0]        funct;
  logic              op_valid;
  logic              flush;
  logic              hold;
  logic [DATA_W-1:0] operand_1;
  logic [DATA_W-1:0] operand_2;
  logic              stall_req;
  logic              done;
  logic [DATA_W-1:0] result_lo;
  logic [DATA_W-1:0] result_hi;

  modport master (
    output funct, op_valid, flush, hold, operand_1, operand_2,
    input  stall_req, done, result_lo, result_hi
  );

  modport slave (
    input  funct, op_valid, flush, hold, operand_1, operand_2,
    output stall_req, done, result_lo, result_hi
  );

endinterface

// File: rtl/div_step.sv
// One restoring division iteration: shift {rem,dvd} left, conditionally subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] dvd,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] dvd_next
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;
  logic              borrow;
  logic              ge;

  assign shifted = {rem, dvd[DATA_W-1]};

  // A set MSB in the 33-bit shifted remainder always exceeds any 32-bit divisor,
  // and the low 32 bits of the difference are then still the correct remainder.
  assign {borrow, diff} = {1'b0, shifted[DATA_W-1:0]} - {1'b0, divisor};
  assign ge             = shifted[DATA_W] | ~borrow;

  assign rem_next = ge ? diff : shifted[DATA_W-1:0];
  assign dvd_next = {dvd[DATA_W-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 DIV/DIVU unit: stalls EX for 33 cycles, then presents LO/HI for one or more DONE cycles.
module div_unit
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dsr_q, dsr_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;

  logic              is_div;
  logic              is_divu;
  logic              req;
  logic              s1;
  logic              s2;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] dvd_step;
  logic              stall;
  logic              done;

  assign is_div  = (bus.funct == FUNCT_DIV);
  assign is_divu = (bus.funct == FUNCT_DIVU);
  assign req     = bus.op_valid & (is_div | is_divu) & ~bus.flush;

  // Signs only matter for DIV; DIVU operands are always treated as magnitudes.
  assign s1 = is_div & bus.operand_1[DATA_W-1];
  assign s2 = is_div & bus.operand_2[DATA_W-1];

  div_step u_step (
    .rem      (rem_q),
    .dvd      (dvd_q),
    .divisor  (dsr_q),
    .rem_next (rem_step),
    .dvd_next (dvd_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    stall   = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (bus.operand_2 == '0) begin
            lo_d    = '1;
            hi_d    = bus.operand_1;
            state_d = DONE;
          end else begin
            dvd_d   = cond_neg(s1, bus.operand_1);
            dsr_d   = cond_neg(s2, bus.operand_2);
            q_neg_d = s1 ^ s2;
            r_neg_d = s1;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          rem_d = rem_step;
          dvd_d = dvd_step;
          cnt_d = cnt_q + 1'b1;
          // Sign correction happens on the final step so the results leave a register.
          if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
            lo_d    = cond_neg(q_neg_q, dvd_step);
            hi_d    = cond_neg(r_neg_q, rem_step);
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          done = 1'b1;
          if (!bus.hold) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign bus.stall_req = stall;
  assign bus.done      = done;
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized bench for div_unit against an arithmetic reference model.
module tb_div_unit;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] last_lo;
  logic [31:0] last_hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS semantics via wide signed/unsigned arithmetic.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (f == FUNCT_DIVU) begin
      lo = a / b;
      hi = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endfunction

  task automatic run_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit rnd_hold);
    logic [31:0] elo, ehi;
    int lat;
    model(f, a, b, elo, ehi);
    lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    bus.funct     = f;
    bus.op_valid  = 1'b1;
    bus.operand_1 = a;
    bus.operand_2 = b;
    bus.hold      = rnd_hold ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    chk("stall_first", 32'(bus.stall_req), 32'd1);
    chk("done_first", 32'(bus.done), 32'd0);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      bus.op_valid  = 1'b0;
      bus.operand_1 = $urandom;
      bus.operand_2 = $urandom;
      if (rnd_hold) bus.hold = 1'($urandom_range(0, 1));
      #1;
      chk("stall_busy", 32'(bus.stall_req), 32'd1);
      chk("done_busy", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.hold     = 1'b0;
    #1;
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("stall_done", 32'(bus.stall_req), 32'd0);
    chk("lo", bus.result_lo, elo);
    chk("hi", bus.result_hi, ehi);
    last_lo = elo;
    last_hi = ehi;
    $display("div funct=%b a=%h b=%h lo=%h hi=%h exp_lo=%h exp_hi=%h",
             f, a, b, bus.result_lo, bus.result_hi, elo, ehi);
  endtask

  initial begin
    logic saw_done;
    logic [5:0] rf;
    logic [31:0] ra, rb;

    rst           = 1'b1;
    bus.funct     = 6'd0;
    bus.op_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.hold      = 1'b0;
    bus.operand_1 = 32'd0;
    bus.operand_2 = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    chk("rst_lo", bus.result_lo, 32'd0);
    chk("rst_hi", bus.result_hi, 32'd0);
    rst = 1'b0;

    run_div(FUNCT_DIVU, 32'd100, 32'd7, 1'b0);
    run_div(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_div(FUNCT_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_div(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(FUNCT_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div(FUNCT_DIVU, 32'd5, 32'd0, 1'b0);

    // Non-divide funct and request-with-flush must both be ignored.
    @(negedge clk);
    bus.funct = 6'b100000; bus.op_valid = 1'b1; bus.operand_2 = 32'd3;
    #1 chk("other_funct_stall", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    bus.funct = FUNCT_DIVU; bus.flush = 1'b1;
    #1 chk("other_funct_done", 32'(bus.done), 32'd0);
    chk("flush_req_stall", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    bus.op_valid = 1'b0; bus.flush = 1'b0;
    #1 chk("flush_req_done", 32'(bus.done), 32'd0);
    chk("flush_req_idle", 32'(bus.stall_req), 32'd0);

    // Flush in BUSY cycle T+10.
    @(negedge clk);
    bus.funct = FUNCT_DIVU; bus.op_valid = 1'b1;
    bus.operand_1 = 32'd1000; bus.operand_2 = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.op_valid = 1'b0;
    end
    bus.flush = 1'b1;
    #1 chk("flush_stall", 32'(bus.stall_req), 32'd0);
    chk("flush_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1 chk("post_flush_stall", 32'(bus.stall_req), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      #1 if (bus.done) saw_done = 1'b1;
    end
    chk("no_done_after_flush", 32'(saw_done), 32'd0);
    chk("flush_keep_lo", bus.result_lo, last_lo);
    chk("flush_keep_hi", bus.result_hi, last_hi);
    run_div(FUNCT_DIVU, 32'd9, 32'd3, 1'b0);

    // Hold keeps DONE and its results stable.
    run_div(FUNCT_DIVU, 32'd50, 32'd6, 1'b0);
    bus.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("hold_done", 32'(bus.done), 32'd1);
      chk("hold_lo", bus.result_lo, 32'd8);
      chk("hold_hi", bus.result_hi, 32'd2);
    end
    bus.hold = 1'b0;
    @(negedge clk);
    #1 chk("hold_release_done", 32'(bus.done), 32'd0);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    bus.funct = FUNCT_DIV; bus.op_valid = 1'b1;
    bus.operand_1 = 32'hFFFF_FC18; bus.operand_2 = 32'd7;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      bus.op_valid = 1'b0;
    end
    rst = 1'b1;
    #1 chk("midrst_stall", 32'(bus.stall_req), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_lo", bus.result_lo, 32'd0);
    chk("midrst_hi", bus.result_hi, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_done", 32'(bus.done), 32'd0);
    run_div(FUNCT_DIV, 32'hFFFF_FC18, 32'd7, 1'b0);

    // Randomized mix, with hold toggling while BUSY.
    for (int n = 0; n < 25; n++) begin
      rf = ($urandom_range(0, 1) == 0) ? FUNCT_DIV : FUNCT_DIVU;
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(0, 3));
      else rb = $urandom >> $urandom_range(0, 31);
      run_div(rf, ra, rb, 1'b1);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider in the EX stage for MIPS DIV and DIVU. It sits directly downstream of the ID-stage funct decoder and consumes the decoded `funct` alongside the two register operands. It stalls the pipeline for the division's duration, then presents quotient (LO) and remainder (HI) for the HI/LO write-back path.

## Interface
- `DATA_W`, 32, operand/result width; `DIV_CYCLES` equals `DATA_W`.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `funct` in 6: decoded funct from ID; `6'b011010` is DIV, `6'b011011` is DIVU, all other values are ignored.
- `op_valid` in 1: EX holds a valid instruction this cycle.
- `flush` in 1: pipeline flush (exception/eret); aborts any division.
- `hold` in 1: downstream stall; freezes DONE.
- `operand_1` in 32: dividend (rs).
- `operand_2` in 32: divisor (rt).
- `stall_req` out 1: request that IF/ID/EX freeze.
- `done` out 1: results valid this cycle.
- `result_lo` out 32: quotient.
- `result_hi` out 32: remainder.

## Operation
- States: IDLE, BUSY, DONE.
- **Request:** `req = op_valid & (funct==DIV | funct==DIVU) & ~flush`.
- **IDLE:**
  - On `req` with `operand_2 != 0`:
    - Latch the operand magnitudes. For DIV, use the absolute value when the sign bit is set; for DIVU, use the raw value.
    - Latch `q_neg = s1^s2` and `r_neg = s1`; both are 0 for DIVU.
    - Clear the 32-bit partial remainder, set the iteration counter to 0, and go to BUSY.
  - On `req` with `operand_2 == 0`:
    - Go to DONE with `result_lo = 32'hFFFF_FFFF` and `result_hi = operand_1`.
    - This is a defined value for an architecturally unpredictable result; no trap.
- **BUSY:** one restoring step per cycle.
  - `{rem,dvd} <<= 1`.
  - If `rem >= divisor`: `rem -= divisor` and the shifted-in quotient bit is 1; otherwise 0.
  - Use a 33-bit compare/subtract.
  - The counter increments each cycle. After step 31 (counter == 31), go to DONE.
- **DONE entry (result correction):**
  - `result_lo = q_neg ? -q : q`.
  - `result_hi = r_neg ? -rem : rem`.
  - Applied in the transition cycle, so outputs are registered.
- **DONE:**
  - `done = 1`.
  - `hold = 1` keeps DONE with the results stable.
  - `hold = 0` goes to IDLE next cycle.
- **Overflow:** `-2^31 / -1` gives `result_lo = 32'h8000_0000`, `result_hi = 0`, no exception.
- **Flush:** from any state, the next state is IDLE; `done` and `stall_req` are 0 in the flush cycle.
  - Results keep their last values.
  - A request in the same cycle as the flush is ignored.
- **Reset:** state IDLE; `done = 0`; `result_lo = result_hi = 0`; counter and internal registers 0.

## Timing
- `stall_req` is combinational:
  - `(state==IDLE & req)` or `(state==BUSY & ~flush)`.
  - It is 0 in DONE, so EX advances and captures results at the DONE edge.
- **Latency:** request seen in IDLE at cycle T.
  - BUSY spans T+1 through T+32.
  - `done` is high at T+33.
  - Stall lasts cycles T through T+32 (33 cycles).
- **Divide by zero:** request at T, `done` at T+1, stall only in cycle T.
- **Back-to-back:** a second division reaching EX in the cycle after DONE starts from IDLE normally. There is no bypass from DONE to BUSY.
- **`hold` outside DONE:** no effect. While BUSY, the divider keeps iterating regardless of `hold`.
- **Mid-operation reset:** asynchronous return to IDLE within the same cycle; outputs go to reset values immediately.

## Structure
- **Shared package `div_pkg`:**
  - `FUNCT_DIV` and `FUNCT_DIVU` constants (identical to the funct header values).
  - State enum `div_state_t` {IDLE, BUSY, DONE}.
  - `DIV_CYCLES` = 32.
- **Sub-module `div_step`:** combinational single restoring iteration.
  - Inputs: `rem`, `dvd`, `divisor`.
  - Outputs: `rem_next`, `dvd_next` with the quotient bit in the LSB.
- **`div_unit`:** holds the FSM, counter, sign correction and output registers.

## Test plan
- **DIVU basic:** DIVU 100/7 at T → `stall_req` high T..T+32; `done` only at T+33 with `lo=14`, `hi=2`.
- **DIV signed:** DIV −7/2 → `lo=32'hFFFF_FFFD`, `hi=32'hFFFF_FFFF`. DIV 7/−2 → `lo=32'hFFFF_FFFD`, `hi=1`.
- **Corner cases:**
  - DIV `32'h8000_0000` / `32'hFFFF_FFFF` → `lo=32'h8000_0000`, `hi=0`.
  - DIVU `32'hFFFF_FFFF` / 1 → `lo=32'hFFFF_FFFF`, `hi=0`.
- **Divide by zero:** DIVU 5/0 → `done` at T+1, `lo=32'hFFFF_FFFF`, `hi=5`, single stall cycle.
- **Flush:** flush asserted in BUSY cycle T+10 → `stall_req` 0 that cycle, IDLE next cycle, no `done` pulse. A following DIVU 9/3 completes in 33 cycles with `lo=3`.
- **Hold and reset:**
  - `hold` high for 3 cycles in DONE → `done` and results stable throughout, IDLE after `hold` drops.
  - `rst` pulsed at T+15 → immediate IDLE, all outputs 0.
